// File: rtl/parity_pkg.sv
// Shared types and helpers for the parity checking pipeline.
// Group width, stage bundle and the 4-input XNOR reduction.
package parity_pkg;

  localparam int GROUP_W    = 4;
  localparam int DATA_MAX_W = 512;

  typedef struct packed {
    logic [DATA_MAX_W-1:0] data;
    logic                  par;
    logic                  valid;
  } par_stage_t;

  function automatic logic xnor4(input logic [GROUP_W-1:0] v);
    return ~^v;
  endfunction

endpackage

// File: rtl/parity_group_reduce.sv
// Combinational bank of 4-input XNOR parity cells.
// One output bit per nibble of the data word.
module parity_group_reduce
  import parity_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0]         data,
  output logic [DATA_W/GROUP_W-1:0] grp
);

  for (genvar i = 0; i < DATA_W / GROUP_W; i++) begin : g_cell
    assign grp[i] = xnor4(data[GROUP_W*i +: GROUP_W]);
  end

endmodule

// File: rtl/parity_check_pipe.sv
// Two-stage valid/ready parity checker with saturating error count.
// Define PARITY_ODD_EN to check odd parity instead of even.
module parity_check_pipe
  import parity_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_par,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              err_sticky,
  input  logic              clr
);

  localparam int   G     = DATA_W / GROUP_W;
  localparam logic G_ODD = (G % 2) == 1;

  if (DATA_W % GROUP_W != 0 || DATA_W < GROUP_W ||
      DATA_W > DATA_MAX_W) begin : g_bad_w
    $error("DATA_W must be a multiple of 4 within range");
  end
  if (CNT_W < 1) begin : g_bad_cnt
    $error("CNT_W must be at least 1");
  end

  par_stage_t      s1_q;
  par_stage_t      s2_q;
  logic [G-1:0]    grp;
  logic [G-1:0]    s1_g;
  logic            s2_err;
  logic            s1_ready;
  logic            s2_ready;
  logic            p;
  logic            err_d;
  logic            err_hs;
  logic            unused_s2;

  parity_group_reduce #(
    .DATA_W(DATA_W)
  ) u_grp (
    .data(in_data),
    .grp (grp)
  );

  assign s2_ready = !s2_q.valid || out_ready;
  assign s1_ready = !s1_q.valid || s2_ready;
  assign in_ready = s1_ready;

  // Nibble XNORs each add an inversion; an odd group count flips p back.
  assign p = (^s1_g) ^ G_ODD;

`ifdef PARITY_ODD_EN
  assign err_d = ~(p ^ s1_q.par);
`else
  assign err_d = p ^ s1_q.par;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_q <= '0;
      s1_g <= '0;
    end else if (s1_ready) begin
      s1_q.valid <= in_valid;
      if (in_valid) begin
        s1_q.data <= DATA_MAX_W'(in_data);
        s1_q.par  <= in_par;
        s1_g      <= grp;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s2_q   <= '0;
      s2_err <= 1'b0;
    end else if (s2_ready) begin
      s2_q.valid <= s1_q.valid;
      if (s1_q.valid) begin
        s2_q.data <= s1_q.data;
        s2_q.par  <= s1_q.par;
        s2_err    <= err_d;
      end
    end
  end

  assign out_valid = s2_q.valid;
  assign out_data  = s2_q.data[DATA_W-1:0];
  assign out_err   = s2_err;
  assign unused_s2 = ^{s2_q.par, s2_q.data};

  assign err_hs = s2_q.valid && out_ready && s2_err;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (clr) begin
      err_cnt    <= err_hs ? CNT_W'(1) : '0;
      err_sticky <= err_hs;
    end else if (err_hs) begin
      if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
      err_sticky <= 1'b1;
    end
  end

endmodule

// File: tb/tb_parity_check_pipe.sv
// Scoreboard bench for parity_check_pipe (DATA_W=32, CNT_W=2).
// Honours PARITY_ODD_EN when building expected error flags.
module tb_parity_check_pipe;

  localparam int DW = 32;
  localparam int CW = 2;

  logic          CLK = 1'b0;
  logic          RST = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_par = 1'b0;
  logic          out_ready = 1'b1;
  logic          clr = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          in_ready;
  logic          out_valid;
  logic [DW-1:0] out_data;
  logic          out_err;
  logic [CW-1:0] err_cnt;
  logic          err_sticky;

  parity_check_pipe #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .CLK       (CLK),
    .RST       (RST),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_par    (in_par),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_err   (out_err),
    .err_cnt   (err_cnt),
    .err_sticky(err_sticky),
    .clr       (clr)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] d;
    logic          e;
  } exp_t;

  exp_t q[$];
  int   n_run  = 0;
  int   n_fail = 0;
  int   mc     = 0;
  logic ms     = 1'b0;

  task automatic check(string nm, logic [63:0] act, logic [63:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic xe(logic e);
`ifdef PARITY_ODD_EN
    return ~e;
`else
    return e;
`endif
  endfunction

  task automatic chk_cnt(string nm, int c, logic s);
`ifndef PARITY_ODD_EN
    check({nm, "_cnt"}, 64'(err_cnt), 64'(c));
    check({nm, "_sticky"}, 64'(err_sticky), 64'(s));
`endif
  endtask

  // Monitor: compare against queue front, track counter model per edge
  always @(negedge CLK) begin
    if (!RST) begin
      logic he;
      he = 1'b0;
      check("in_ready", 64'(in_ready),
            64'(q.size() < 2 || out_ready));
      check("err_cnt_mdl", 64'(err_cnt), 64'(mc));
      check("sticky_mdl", 64'(err_sticky), 64'(ms));
      if (out_valid) begin
        if (q.size() == 0) begin
          n_run++;
          n_fail++;
          $display("FAIL unexpected_out: got %0h expected none",
                   out_data);
        end else begin
          check("out_data", 64'(out_data), 64'(q[0].d));
          check("out_err", 64'(out_err), 64'(q[0].e));
          if (out_ready) begin
            he = q[0].e;
            void'(q.pop_front());
          end
        end
      end
      if (clr) begin
        mc = he ? 1 : 0;
        ms = he;
      end else if (he) begin
        if (mc != (1 << CW) - 1) mc++;
        ms = 1'b1;
      end
    end
  end

  task automatic send(logic [DW-1:0] d, logic p, logic e);
    logic ok;
    ok = 1'b0;
    in_data  = d;
    in_par   = p;
    in_valid = 1'b1;
    for (int k = 0; k < 100 && !ok; k++) begin
      @(negedge CLK);
      ok = in_ready;
      @(posedge CLK);
      if (ok) q.push_back('{d: d, e: xe(e)});
      #1;
    end
    in_valid = 1'b0;
    if (!ok) begin
      n_run++;
      n_fail++;
      $display("FAIL send_timeout: got no in_ready expected ready");
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 100 && q.size() != 0; k++) begin
      @(posedge CLK);
      #1;
    end
    if (q.size() != 0) begin
      n_run++;
      n_fail++;
      $display("FAIL drain_timeout: got %0d queued expected 0",
               q.size());
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  logic [DW-1:0] sd [8] = '{32'hA5A5_A5A5, 32'h1234_5678,
                            32'h0000_0003, 32'h8000_0000,
                            32'hDEAD_BEEF, 32'hFFFF_FFFE,
                            32'h0F0F_0F0F, 32'hCAFE_F00D};
  logic          sp [8] = '{0, 1, 1, 0, 0, 1, 1, 0};
  logic          se [8] = '{0, 0, 1, 1, 0, 0, 1, 0};
  logic          pat [4] = '{1, 0, 0, 1};

  initial begin
    #1 RST = 1'b1;
    tick();
    tick();
    check("rst_out_valid", 64'(out_valid), 0);
    check("rst_out_data", 64'(out_data), 0);
    check("rst_out_err", 64'(out_err), 0);
    check("rst_err_cnt", 64'(err_cnt), 0);
    check("rst_sticky", 64'(err_sticky), 0);
    RST = 1'b0;
    #1 check("rst_in_ready", 64'(in_ready), 1);
    tick();

    // 1: clean word, 2-cycle latency
    out_ready = 1'b1;
    send(32'h0000_0001, 1'b1, 1'b0);
    check("lat_s1", 64'(out_valid), 0);
    tick();
    check("lat_s2", 64'(out_valid), 1);
    drain();
    chk_cnt("t1", 0, 1'b0);

    // 2: all-ones with par=1 is an even-parity error
    send(32'hFFFF_FFFF, 1'b1, 1'b1);
    drain();
    chk_cnt("t2", 1, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_cnt("t2_clr", 0, 1'b0);

    // 3: 8 words under 1,0,0,1 backpressure
    fork
      begin
        for (int i = 0; i < 8; i++) send(sd[i], sp[i], se[i]);
      end
      begin
        for (int i = 0; i < 40; i++) begin
          tick();
          out_ready = pat[i % 4];
        end
      end
    join
    out_ready = 1'b1;
    drain();
    chk_cnt("t3", 3, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;

    // 4: saturation at 3
    for (int i = 0; i < 5; i++) begin
      send(32'hFFFF_FFFF, 1'b1, 1'b1);
      drain();
      chk_cnt($sformatf("t4_%0d", i), (i < 3) ? i + 1 : 3, 1'b1);
    end

    // 5: clr coincident with an error handshake, then clr alone
    out_ready = 1'b0;
    send(32'hFFFF_FFFF, 1'b1, 1'b1);
    for (int k = 0; k < 20 && !out_valid; k++) tick();
    clr = 1'b1;
    out_ready = 1'b1;
    tick();
    clr = 1'b0;
    chk_cnt("t5_clr_err", 1, 1'b1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk_cnt("t5_clr", 0, 1'b0);

    // 6: reset with two words in flight
    send(32'hFFFF_FFFF, 1'b1, 1'b1);
    drain();
    chk_cnt("t6_pre", 1, 1'b1);
    out_ready = 1'b0;
    send(32'h1111_1111, 1'b0, 1'b0);
    send(32'h0000_0007, 1'b0, 1'b1);
    check("t6_full_ready", 64'(in_ready), 0);
    RST = 1'b1;
    q.delete();
    mc = 0;
    ms = 1'b0;
    #1;
    check("t6_out_valid", 64'(out_valid), 0);
    check("t6_out_data", 64'(out_data), 0);
    check("t6_err_cnt", 64'(err_cnt), 0);
    check("t6_sticky", 64'(err_sticky), 0);
    tick();
    RST = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 10; k++) tick();
    check("t6_in_ready", 64'(in_ready), 1);
    check("t6_cnt_after", 64'(err_cnt), 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
